// File: rtl/spi_seq.sv
// spi_seq: queues host bytes, strobes each into spi_ctrl, captures replies into an RX FIFO; strobe lands 1 cycle after TX pop.
// Backpressure via tx_ready/rx_valid FIFO flags; issue stalls when RX is full. Busy timeout is built only with SPI_SEQ_TIMEOUT_EN.
module spi_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module spi_seq #(
  parameter int FIFO_DEPTH = 8,
  parameter int TMO_CYCLES = 131071
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cfg_div,
  input  logic        cfg_cs,
  input  logic        cfg_en,
  input  logic        rx_discard,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        seq_busy,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] spi_datain,
  input  logic [15:0] spi_dataout,
  output logic        spi_wrh_n
);
  typedef enum logic [1:0] {IDLE, ISSUE, START, WAIT} state_t;

  state_t     state;
  logic [7:0] tx_byte;
  logic [7:0] ctl;
  logic [7:0] tx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_pop, rx_push, tmo_hit, err_q;
  logic       ctrl_busy;
  logic       unused_dout;

  assign ctrl_busy   = spi_dataout[7];
  assign unused_dout = ^spi_dataout[6:0];

  assign tx_ready   = ~tx_full;
  assign rx_valid   = ~rx_empty;
  assign seq_busy   = (state != IDLE) | ~tx_empty;
  assign err        = err_q;
  assign spi_datain = {tx_byte, ctl};

  // RX space is reserved at issue time, so the later capture can never overflow.
  assign tx_pop  = (state == IDLE) & ~tx_empty & cfg_en & ~err_q & (rx_discard | ~rx_full);
  assign rx_push = (state == WAIT) & ~ctrl_busy & ~rx_discard & ~tmo_hit;

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tmo_hit),
    .push  (tx_valid & tx_ready),
    .din   (tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (rx_push),
    .din   (spi_dataout[15:8]),
    .pop   (rx_valid & rx_ready),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = ((state == START) || (state == WAIT)) && (tmo_cnt == CW'(TMO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state == START) || (state == WAIT)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                     tmo_cnt <= '0;
      if (tmo_hit)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign err_q      = 1'b0;
  assign unused_tmo = err_clr ^ (TMO_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      spi_wrh_n <= 1'b1;
      tx_byte   <= 8'h00;
      ctl       <= 8'h00;
    end else begin
      ctl <= {1'b0, cfg_en, cfg_cs, cfg_div};
      case (state)
        IDLE: if (tx_pop) begin
          state     <= ISSUE;
          tx_byte   <= tx_head;
          spi_wrh_n <= 1'b0;
        end
        ISSUE: begin
          state     <= START;
          spi_wrh_n <= 1'b1;
        end
        START: begin
          if (tmo_hit)        state <= IDLE;
          else if (ctrl_busy) state <= WAIT;
        end
        WAIT: if (tmo_hit || !ctrl_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_seq.sv
// Bench for spi_seq: behavioural spi_ctrl model plus byte-order queues for TX issue and RX capture.
module tb_spi_seq;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 131071;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_div = 4'd0;
  logic        cfg_cs = 1'b0;
  logic        cfg_en = 1'b0;
  logic        rx_discard = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        seq_busy;
  logic        err;
  logic        err_clr = 1'b0;
  logic [15:0] spi_datain;
  logic [15:0] spi_dataout;
  logic        spi_wrh_n;

  int errors = 0;
  int checks = 0;

  spi_seq #(.FIFO_DEPTH(8), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_cs(cfg_cs), .cfg_en(cfg_en),
    .rx_discard(rx_discard), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .seq_busy(seq_busy),
    .err(err), .err_clr(err_clr), .spi_datain(spi_datain), .spi_dataout(spi_dataout),
    .spi_wrh_n(spi_wrh_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte streams: bytes accepted for transmit, and replies owed to the host.
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  // spi_ctrl stand-in: busy follows a sampled strobe, lasts 4*(div+1) cycles, reply = sent ^ mask.
  logic       c_busy = 1'b0;
  logic [7:0] c_shreg = 8'h00;
  logic [7:0] c_cur = 8'h00;
  int         c_cnt = 0;
  logic       hold_busy = 1'b0;
  logic       ctrl_kill = 1'b0;
  logic [7:0] miso_mask = 8'h00;

  assign spi_dataout = {c_shreg, c_busy, 7'h00};

  always @(posedge clk) begin
    if (rst || ctrl_kill) begin
      c_busy  <= 1'b0;
      c_cnt   <= 0;
      c_shreg <= 8'h00;
    end else if (!c_busy) begin
      if (!spi_wrh_n) begin
        c_busy <= 1'b1;
        c_cur  <= spi_datain[15:8];
        c_cnt  <= 4 * (int'(spi_datain[3:0]) + 1);
      end
    end else if (!hold_busy) begin
      if (c_cnt <= 1) begin
        c_busy  <= 1'b0;
        c_shreg <= c_cur ^ miso_mask;
        if (!rx_discard) rx_exp.push_back(c_cur ^ miso_mask);
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end
  end

  int   strobes = 0;
  logic prev_low = 1'b0;
  logic rx_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!spi_wrh_n) begin
        strobes++;
        check("strobe_width", 32'(prev_low), 0);
        check("one_in_flight", 32'(c_busy), 0);
        if (tx_exp.size() == 0) check("strobe_unexpected", 1, 0);
        else check("strobe_byte", 32'(spi_datain[15:8]), 32'(tx_exp.pop_front()));
      end
      prev_low = !spi_wrh_n;
      if (rx_discard && rx_valid) rx_seen = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input int budget);
    int b = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && b < budget) begin
      tick();
      b++;
    end
    check("push_ready", 32'(tx_ready), 1);
    if (tx_ready) tx_exp.push_back(d);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    int b = 0;
    while (strobes < target && b < budget) begin
      tick();
      b++;
    end
    check(tag, 32'(strobes >= target), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int b = 0;
    while ((seq_busy || c_busy) && b < budget) begin
      tick();
      b++;
    end
    check(tag, 32'(seq_busy), 0);
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while ((rx_exp.size() != 0 || rx_valid) && b < 400) begin
      if (rx_valid) begin
        if (rx_exp.size() == 0) check({tag, "_extra"}, 1, 0);
        else check(tag, 32'(rx_data), 32'(rx_exp.pop_front()));
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end else begin
        tick();
      end
      b++;
    end
    check({tag, "_empty"}, 32'(rx_valid), 0);
    check({tag, "_left"}, 32'(rx_exp.size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset values
    rst = 1'b1;
    tick(3);
    check("rst_wrh_n", 32'(spi_wrh_n), 1);
    check("rst_datain", 32'(spi_datain), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_seq_busy", 32'(seq_busy), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;

    // Single byte, loopback, latency and strobe shape
    cfg_div = 4'd0; cfg_cs = 1'b1; cfg_en = 1'b1; miso_mask = 8'h00;
    tick(2);
    base = strobes;
    tx_data = 8'hA5; tx_valid = 1'b1; tx_exp.push_back(8'hA5);
    tick();
    tx_valid = 1'b0;
    check("t1_pre_strobe", 32'(spi_wrh_n), 1);
    check("t1_busy", 32'(seq_busy), 1);
    tick();
    check("t1_strobe_low", 32'(spi_wrh_n), 0);
    check("t1_datain", 32'(spi_datain), 32'h0000A530);
    tick();
    check("t1_strobe_high", 32'(spi_wrh_n), 1);
    wait_idle(200, "t1_idle");
    check("t1_count", 32'(strobes - base), 1);
    check("t1_rx_valid", 32'(rx_valid), 1);
    check("t1_rx_data", 32'(rx_data), 32'h000000A5);
    drain("t1_rx");

    // Burst of 8 into RX with no pops; 9th must wait for RX space
    cfg_en = 1'b0; cfg_div = 4'($urandom_range(0, 3)); miso_mask = 8'($urandom);
    rx_ready = 1'b0;
    tick(2);
    base = strobes;
    for (int i = 1; i <= 8; i++) push(8'(i), 10);
    check("t2_tx_full", 32'(tx_ready), 0);
    check("t2_busy_gated", 32'(seq_busy), 1);
    cfg_en = 1'b1;
    wait_strobes(base + 8, 600, "t2_eight");
    wait_idle(200, "t2_idle");
    check("t2_rx_valid", 32'(rx_valid), 1);
    push(8'h09, 10);
    tick(40);
    check("t2_hold9", 32'(strobes - base), 8);
    check("t2_busy9", 32'(seq_busy), 1);
    check("t2_pop1", 32'(rx_data), 32'(rx_exp.pop_front()));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    wait_strobes(base + 9, 10, "t2_issue9");
    wait_idle(200, "t2_idle9");
    drain("t2_rx");

    // Discard mode: 16 strobes, nothing captured
    rx_discard = 1'b1; cfg_div = 4'($urandom_range(0, 3)); miso_mask = 8'($urandom);
    rx_seen = 1'b0;
    tick(2);
    base = strobes;
    for (int i = 0; i < 16; i++) push(8'($urandom), 400);
    wait_strobes(base + 16, 800, "t3_sixteen");
    wait_idle(200, "t3_idle");
    check("t3_count", 32'(strobes - base), 16);
    check("t3_rx_seen", 32'(rx_seen), 0);
    check("t3_rx_valid", 32'(rx_valid), 0);
    rx_discard = 1'b0;
    tick();

    // cfg_en gating
    cfg_en = 1'b0; miso_mask = 8'($urandom);
    tick(2);
    base = strobes;
    for (int i = 0; i < 3; i++) push(8'($urandom), 10);
    tick(20);
    check("t4_no_strobe", 32'(strobes - base), 0);
    check("t4_busy", 32'(seq_busy), 1);
    cfg_en = 1'b1;
    tick(2);
    check("t4_quick", 32'(strobes - base), 1);
    wait_strobes(base + 3, 300, "t4_three");
    wait_idle(200, "t4_idle");
    drain("t4_rx");

`ifdef SPI_SEQ_TIMEOUT_EN
    // Busy stuck high: err after 100 cycles in START/WAIT, TX flushed
    cfg_en = 1'b0; hold_busy = 1'b1;
    tick(2);
    base = strobes;
    push(8'h3C, 10); push(8'h11, 10); push(8'h22, 10);
    cfg_en = 1'b1;
    tick();
    check("t5_strobe", 32'(strobes - base), 1);
    tick(100);
    check("t5_err_early", 32'(err), 0);
    check("t5_busy_early", 32'(seq_busy), 1);
    tick();
    check("t5_err_set", 32'(err), 1);
    check("t5_flushed", 32'(seq_busy), 0);
    check("t5_tx_ready", 32'(tx_ready), 1);
    check("t5_no_rx", 32'(rx_valid), 0);
    tx_exp.delete();
    push(8'h44, 10);
    tick(10);
    check("t5_blocked", 32'(strobes - base), 1);
    check("t5_err_sticky", 32'(err), 1);
    hold_busy = 1'b0; ctrl_kill = 1'b1;
    tick();
    ctrl_kill = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_err_clr", 32'(err), 0);
    wait_strobes(base + 2, 10, "t5_resume");
    wait_idle(200, "t5_idle");
    drain("t5_rx");
`endif

    // Reset during WAIT abandons the byte
    cfg_en = 1'b1; cfg_div = 4'($urandom_range(1, 3));
    tick(2);
    base = strobes;
    push(8'h5A, 10);
    push(8'h66, 10);
    check("t6_strobe", 32'(strobes - base), 1);
    tick(3);
    check("t6_in_flight", 32'(c_busy), 1);
    rst = 1'b1;
    tick();
    check("t6_wrh_n", 32'(spi_wrh_n), 1);
    check("t6_datain", 32'(spi_datain), 0);
    check("t6_tx_ready", 32'(tx_ready), 1);
    check("t6_rx_valid", 32'(rx_valid), 0);
    check("t6_seq_busy", 32'(seq_busy), 0);
    rst = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    tick(10);
    check("t6_no_strobe", 32'(strobes - base), 1);
    check("t6_no_rx", 32'(rx_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
